// File: rtl/dl_rom_loader_if.sv
// ioctl download bus from the host loader.
//   ioctl_download : high for the whole download session
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address of ioctl_dout
//   ioctl_dout     : download byte
// master = host side (drives), slave = loader side (receives).
interface dl_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/dl_rom_loader.sv
// ROM image loader: takes the ioctl byte stream, splits it into the
// program / playfield / motion-object / PROM regions, tracks a running
// checksum and byte count, flags range/sequence/size errors, and holds the
// game core in reset until the image has settled.
// Ports:
//   clk_sys, reset         : clock, synchronous active-high system reset
//   ioctl                  : download bus (slave modport)
//   wr_addr, wr_data       : registered region-local address and byte
//   prog_we/pf_we/mo_we/prom_we : one-cycle write enables (one-hot or zero)
//   core_reset             : holds the core in reset (low only in DONE)
//   rom_loaded             : image complete and error-free
//   checksum, byte_count   : additive sum / count of accepted bytes
//   err_range/err_seq/err_size : sticky error flags, cleared on new download
module dl_rom_loader #(
  parameter int          FLUSH_CYCLES  = 16,
  parameter logic [12:0] EXPECTED_SIZE = 13'h1F00
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  dl_rom_loader_if.slave        ioctl,
  output logic [12:0]           wr_addr,
  output logic [7:0]            wr_data,
  output logic                  prog_we,
  output logic                  pf_we,
  output logic                  mo_we,
  output logic                  prom_we,
  output logic                  core_reset,
  output logic                  rom_loaded,
  output logic [15:0]           checksum,
  output logic [15:0]           byte_count,
  output logic                  err_range,
  output logic                  err_seq,
  output logic                  err_size
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic          dl_prev;
  logic          dl_rise, dl_fall;
  logic [CW-1:0] flush_cnt;
  logic [24:0]   exp_next;
  logic [3:0]    we_q;       // {prog, pf, mo, prom}
  logic [3:0]    dec_we;
  logic [12:0]   dec_addr;
  logic          in_window, in_range, accept;
  logic          enter_load, enter_flush, enter_done;
  logic [15:0]   cnt_nxt;

  // Edge detector; dl_prev resets to 0 so a download already high when
  // reset releases is seen as a rising edge.
  assign dl_rise = ioctl.ioctl_download & ~dl_prev;
  assign dl_fall = ~ioctl.ioctl_download & dl_prev;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (dl_rise) state_nxt = LOAD;
      LOAD:       if (dl_fall) state_nxt = FLUSH;
      FLUSH: begin
        if (dl_rise)             state_nxt = LOAD;
        else if (flush_cnt == '0) state_nxt = DONE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  assign enter_load  = (state_nxt == LOAD) && (state != LOAD);
  assign enter_flush = (state == LOAD) && (state_nxt == FLUSH);
  assign enter_done  = (state == FLUSH) && (state_nxt == DONE);

  // The last byte may arrive in the same cycle the download drops.
  assign in_window = ioctl.ioctl_wr && ((state == LOAD) || dl_fall);
  assign in_range  = ioctl.ioctl_addr < {12'd0, EXPECTED_SIZE};
  assign accept    = in_window && in_range;
  assign cnt_nxt   = (accept && byte_count != 16'hFFFF) ? byte_count + 16'd1
                                                        : byte_count;

  // Region decode; addresses past the PROM window hit no region.
  always_comb begin
    dec_we   = 4'b0000;
    dec_addr = ioctl.ioctl_addr[12:0];
    if (ioctl.ioctl_addr < 25'h1800) begin
      dec_we = 4'b1000;
    end else if (ioctl.ioctl_addr < 25'h1C00) begin
      dec_we   = 4'b0100;
      dec_addr = ioctl.ioctl_addr[12:0] - 13'h1800;
    end else if (ioctl.ioctl_addr < 25'h1E00) begin
      dec_we   = 4'b0010;
      dec_addr = ioctl.ioctl_addr[12:0] - 13'h1C00;
    end else if (ioctl.ioctl_addr < 25'h1F00) begin
      dec_we   = 4'b0001;
      dec_addr = ioctl.ioctl_addr[12:0] - 13'h1E00;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      dl_prev    <= 1'b0;
      flush_cnt  <= '0;
      exp_next   <= '0;
      we_q       <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      checksum   <= '0;
      byte_count <= '0;
      err_range  <= 1'b0;
      err_seq    <= 1'b0;
      err_size   <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      state   <= state_nxt;
      dl_prev <= ioctl.ioctl_download;

      if (enter_flush)
        flush_cnt <= CW'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;

      we_q <= accept ? dec_we : 4'b0000;
      if (accept && dec_we != 4'b0000) begin
        wr_addr <= dec_addr;
        wr_data <= ioctl.ioctl_dout;
      end

      if (enter_load) begin
        checksum   <= '0;
        byte_count <= '0;
        err_range  <= 1'b0;
        err_seq    <= 1'b0;
        err_size   <= 1'b0;
        rom_loaded <= 1'b0;
        exp_next   <= '0;
      end else begin
        if (accept) begin
          checksum   <= checksum + {8'd0, ioctl.ioctl_dout};
          byte_count <= cnt_nxt;
        end
        if (in_window && !in_range)
          err_range <= 1'b1;
        if (in_window && in_range) begin
          if (ioctl.ioctl_addr != exp_next) err_seq <= 1'b1;
          exp_next <= ioctl.ioctl_addr + 25'd1;
        end
        // Size check sees the count including a same-cycle final byte.
        if (enter_flush && cnt_nxt != {3'd0, EXPECTED_SIZE})
          err_size <= 1'b1;
        if (enter_done && !(err_range || err_seq || err_size))
          rom_loaded <= 1'b1;
      end
    end
  end

  assign {prog_we, pf_we, mo_we, prom_we} = we_q;
  assign core_reset = (state != DONE);

endmodule

// File: tb/tb_dl_rom_loader.sv
`timescale 1ns/1ps
module tb_dl_rom_loader;
  localparam int FLUSH = 16;
  localparam int SIZE  = 'h1F00;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        prog_we, pf_we, mo_we, prom_we;
  logic        core_reset, rom_loaded;
  logic [15:0] checksum, byte_count;
  logic        err_range, err_seq, err_size;

  dl_rom_loader_if bus ();

  dl_rom_loader #(.FLUSH_CYCLES(FLUSH), .EXPECTED_SIZE(13'h1F00)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl(bus),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_we(prog_we), .pf_we(pf_we), .mo_we(mo_we), .prom_we(prom_we),
    .core_reset(core_reset), .rom_loaded(rom_loaded),
    .checksum(checksum), .byte_count(byte_count),
    .err_range(err_range), .err_seq(err_seq), .err_size(err_size)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Reference model: what a download session should produce.
  typedef struct {
    logic [3:0]  we;
    logic [12:0] a;
    logic [7:0]  d;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  bit          in_session;
  int          m_count;
  logic [15:0] m_sum;
  bit          m_range, m_seq, m_size;
  int          m_next;
  int          n_reg[4];
  logic [12:0] last_a;
  logic [7:0]  last_d;
  logic        rst_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    m_count = 0; m_sum = 0; m_range = 0; m_seq = 0; m_size = 0; m_next = 0;
    for (int i = 0; i < 4; i++) n_reg[i] = 0;
  endfunction

  function automatic void model_byte(input int a, input logic [7:0] d);
    wr_t e;
    if (!in_session) return;
    if (a >= SIZE) begin m_range = 1; return; end
    if (m_count < 65535) m_count++;
    m_sum += 16'(d);
    if (a != m_next) m_seq = 1;
    m_next = a + 1;
    if (a < 'h1800)      begin e.we = 4'b1000; e.a = 13'(a); end
    else if (a < 'h1C00) begin e.we = 4'b0100; e.a = 13'(a - 'h1800); end
    else if (a < 'h1E00) begin e.we = 4'b0010; e.a = 13'(a - 'h1C00); end
    else                 begin e.we = 4'b0001; e.a = 13'(a - 'h1E00); end
    e.d = d;
    e.due = cyc + 1;
    exp_q.push_back(e);
  endfunction

  // Write-port monitor: every enable must match the next expected write,
  // arrive exactly one cycle after its strobe, and address/data must hold
  // while no enable is high.
  always @(posedge clk_sys) rst_seen <= reset;

  always @(negedge clk_sys) begin
    logic [3:0] we;
    wr_t e;
    we = {prog_we, pf_we, mo_we, prom_we};
    if (rst_seen) begin
      last_a = '0; last_d = '0;
    end else if (we != 4'b0000) begin
      chk("unexpected_write", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_en", we, e.we);
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
        chk("wr_latency", cyc, e.due);
        last_a = e.a; last_d = e.d;
      end
      for (int i = 0; i < 4; i++) if (we[3-i]) n_reg[i]++;
    end else if (!reset) begin
      chk("wr_hold", {wr_addr, wr_data}, {last_a, last_d});
    end
  end

  task automatic start_dl();
    bus.ioctl_download = 1'b1;
    in_session = 1;
    model_clear();
    @(negedge clk_sys);
    chk("load_core_reset", core_reset, 1'b1);
    chk("load_clear_count", byte_count, 16'd0);
  endtask

  task automatic strobe(input int a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = d;
    model_byte(a, d);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  // Drop the download (optionally with a final byte in that same cycle),
  // then measure how long core_reset stays high after the drop is sampled.
  task automatic finish_dl(input bit same_cycle, input int a, input logic [7:0] d);
    int n;
    if (same_cycle) begin
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = d;
      model_byte(a, d);
    end
    bus.ioctl_download = 1'b0;
    in_session = 0;
    m_size = (m_count != SIZE);
    n = 0;
    do begin
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      n++;
    end while (core_reset && n < 200);
    chk("flush_cycles", n - 1, FLUSH);
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_checksum"}, checksum, m_sum);
    chk({tag, "_count"}, byte_count, 16'(m_count));
    chk({tag, "_err_range"}, err_range, m_range);
    chk({tag, "_err_seq"}, err_seq, m_seq);
    chk({tag, "_err_size"}, err_size, m_size);
    chk({tag, "_rom_loaded"}, rom_loaded, !(m_range || m_seq || m_size));
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.ioctl_download = 1'b0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    in_session = 0;
    model_clear();
    repeat (3) @(negedge clk_sys);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_outputs", {prog_we, pf_we, mo_we, prom_we, rom_loaded, err_range, err_seq, err_size}, 8'h00);
    chk("rst_counters", {checksum, byte_count, wr_addr, wr_data}, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("idle_core_reset", core_reset, 1'b1);
    strobe(5, 8'hAA);                       // ignored outside a session
    @(negedge clk_sys);
    chk("idle_ignored", byte_count, 16'd0);

    // Full image, byte value = addr[7:0], back-to-back strobes.
    start_dl();
    for (int a = 0; a < SIZE; a++) strobe(a, 8'(a));
    finish_dl(0, 0, 8'h00);
    check_final("full");
    chk("full_prog", n_reg[0], 6144);
    chk("full_pf", n_reg[1], 1024);
    chk("full_mo", n_reg[2], 512);
    chk("full_prom", n_reg[3], 256);
    // 31 pages of 0..255 sum to 0xF7080; the low 16 bits remain.
    chk("full_checksum_const", checksum, 16'h7080);
    for (int i = 0; i < 4; i++) strobe($urandom_range(0, SIZE - 1), 8'($urandom));
    chk("done_ignored", byte_count, 16'(SIZE));
    chk("done_core_reset", core_reset, 1'b0);

    // Random data with idle gaps; last byte shares its cycle with the drop.
    start_dl();
    for (int a = 0; a < SIZE - 1; a++) begin
      strobe(a, 8'($urandom));
      if ($urandom_range(0, 7) == 0) @(negedge clk_sys);
    end
    finish_dl(1, SIZE - 1, 8'($urandom));
    check_final("samecyc");

    // Full image plus one out-of-range strobe.
    start_dl();
    for (int a = 0; a < SIZE; a++) begin
      strobe(a, 8'($urandom));
      if ($urandom_range(0, 15) == 0) @(negedge clk_sys);
    end
    strobe(SIZE, 8'h5A);
    finish_dl(0, 0, 8'h00);
    check_final("range");
    chk("range_err", err_range, 1'b1);

    // Address gap 0, 1, 3.
    start_dl();
    strobe(0, 8'h11); strobe(1, 8'h22); strobe(3, 8'h33);
    finish_dl(0, 0, 8'h00);
    check_final("gap");
    chk("gap_seq", err_seq, 1'b1);

    // Program / playfield boundary.
    start_dl();
    strobe('h17FF, 8'($urandom)); strobe('h1800, 8'($urandom));
    finish_dl(0, 0, 8'h00);
    check_final("bound");
    chk("bound_prog", n_reg[0], 1);
    chk("bound_pf", n_reg[1], 1);

    // Reset in the middle of FLUSH, then a download already high at release.
    start_dl();
    for (int a = 0; a < 4; a++) strobe(a, 8'($urandom));
    bus.ioctl_download = 1'b0;
    in_session = 0;
    repeat (11) @(negedge clk_sys);
    chk("midflush_core_reset", core_reset, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("flushrst_core_reset", core_reset, 1'b1);
    chk("flushrst_flags", {rom_loaded, err_range, err_seq, err_size}, 4'h0);
    chk("flushrst_counters", {checksum, byte_count}, 32'h0);
    repeat (FLUSH) @(negedge clk_sys);
    chk("flushrst_held", core_reset, 1'b1);
    bus.ioctl_download = 1'b1;
    in_session = 1;
    model_clear();
    reset = 1'b0;
    @(negedge clk_sys);
    for (int a = 0; a < 8; a++) strobe(a, 8'($urandom));
    finish_dl(0, 0, 8'h00);
    check_final("restart");
    chk("restart_count", byte_count, 16'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
